// File: rtl/onehot_decode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decode_fifo
// Brief    : Queued binary-to-one-hot decoder with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_decode_fifo #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_onehot,
    output logic [IN_W-1:0]          out_code,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [IN_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;
    logic [c_PTR_W:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [IN_W-1:0]    w_head;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign level     = r_count;

    // Gate the head read so stale or unwritten memory never reaches the outputs.
    assign w_head    = out_valid ? r_mem[r_rp] : '0;
    assign out_code  = w_head;

    always_comb begin
        out_onehot = '0;
        if (out_valid) begin
            out_onehot[w_head] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wp] <= in_code;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_decode_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_decode_fifo
// Brief    : Directed plus random stimulus against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_decode_fifo;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic [IN_W-1:0]  out_code;
    logic [2:0]       level;

    int n_checks = 0;
    int n_err    = 0;
    int q[$];

    always #5 clk = ~clk;

    onehot_decode_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .level      (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived directly from the reference queue contents.
    task automatic model_check();
        logic [IN_W-1:0]  ec;
        logic [OUT_W-1:0] eoh;
        ec  = (q.size() != 0) ? IN_W'(q[0]) : '0;
        eoh = (q.size() != 0) ? (OUT_W'(1) << ec) : '0;
        chk("m_out_valid",  32'(out_valid),  32'(q.size() != 0));
        chk("m_in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
        chk("m_level",      32'(level),      32'(q.size()));
        chk("m_out_code",   32'(out_code),   32'(ec));
        chk("m_out_onehot", 32'(out_onehot), 32'(eoh));
    endtask

    task automatic cycle(input logic v, input logic [IN_W-1:0] c, input logic r, input logic f);
        bit push;
        bit pop;
        @(negedge clk);
        in_valid  = v;
        in_code   = c;
        out_ready = r;
        flush     = f;
        model_check();
        pop  = r && (q.size() > 0);
        push = v && (q.size() < DEPTH);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(int'(c));
        end
        #1;
    endtask

    initial begin
        logic [OUT_W-1:0] drain_exp [4];
        drain_exp[0] = 8'h02;
        drain_exp[1] = 8'h04;
        drain_exp[2] = 8'h08;
        drain_exp[3] = 8'h80;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;

        // 1. reset and single transfer
        #12;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_onehot", 32'(out_onehot), 32'h00);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_level",      32'(level),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 3'd5, 1'b0, 1'b0);
        chk("t1_out_valid",  32'(out_valid),  32'd1);
        chk("t1_out_onehot", 32'(out_onehot), 32'h20);
        chk("t1_out_code",   32'(out_code),   32'd5);
        chk("t1_level",      32'(level),      32'd1);
        cycle(1'b0, 3'd0, 1'b1, 1'b0);
        chk("t1_empty", 32'(out_valid), 32'd0);

        // 2. fill and stall
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b0, 1'b0);
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_level_full",    32'(level),    32'd4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd7, 1'b0, 1'b0);
        chk("t2_level_held", 32'(level), 32'd4);
        cycle(1'b1, 3'd7, 1'b1, 1'b0);
        chk("t2_in_ready_after_pop", 32'(in_ready), 32'd1);
        cycle(1'b1, 3'd7, 1'b0, 1'b0);
        chk("t2_level_refill", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain", 32'(out_onehot), 32'(drain_exp[i]));
            cycle(1'b0, 3'd0, 1'b1, 1'b0);
        end
        chk("t2_drained", 32'(level), 32'd0);

        // 3. streaming with wrap
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 3'(i % 8), 1'b1, 1'b0);
            chk("t3_level", 32'(level),    32'd1);
            chk("t3_code",  32'(out_code), 32'(i % 8));
        end
        cycle(1'b0, 3'd0, 1'b1, 1'b0);

        // 4. simultaneous push/pop at level 2
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 1'b1, 1'b0);
        chk("t4_level", 32'(level),    32'd2);
        chk("t4_head",  32'(out_code), 32'd2);

        // 5. flush with concurrent push
        cycle(1'b1, 3'd4, 1'b0, 1'b0);
        chk("t5_level3", 32'(level), 32'd3);
        cycle(1'b1, 3'd6, 1'b0, 1'b1);
        chk("t5_flush_level", 32'(level),     32'd0);
        chk("t5_flush_valid", 32'(out_valid), 32'd0);
        cycle(1'b1, 3'd6, 1'b0, 1'b0);
        chk("t5_onehot", 32'(out_onehot), 32'h40);

        // 6. asynchronous reset mid-stream
        cycle(1'b1, 3'd1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0);
        chk("t6_level3", 32'(level), 32'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("t6_out_valid",  32'(out_valid),  32'd0);
        chk("t6_out_onehot", 32'(out_onehot), 32'h00);
        chk("t6_out_code",   32'(out_code),   32'd0);
        chk("t6_level",      32'(level),      32'd0);
        chk("t6_in_ready",   32'(in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 3'd4, 1'b0, 1'b0);
        chk("t6_onehot", 32'(out_onehot), 32'h10);

        // random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        cycle(1'b0, 3'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_decode_fifo.md
Name: onehot_decode_fifo

Overview:
- Binary-to-one-hot decoder with a small input queue; the inverse of the team's 8-to-3 priority encoder (code 0 maps to bit 0).
- Producers push 3-bit indices over a valid/ready handshake.
- Consumer receives one one-hot vector per accepted index, in order, over a second valid/ready handshake.
- Sits between arbitration/index logic and per-line enable/grant fan-out.

Parameters:
- IN_W, 3, code width.
- OUT_W, 8, one-hot width; must equal 2**IN_W.
- DEPTH, 4, queue entries; power of 2, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous queue clear
- in_valid  input  1  producer has a code
- in_ready  output  1  queue can accept
- in_code  input  IN_W  index to decode
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head
- out_onehot  output  OUT_W  decoded head; bit in_code set
- out_code  output  IN_W  raw head code
- level  output  clog2(DEPTH)+1  entries currently stored

Behaviour:
- Storage: DEPTH x IN_W register array; write pointer wp, read pointer rp (clog2(DEPTH) bits, wrap mod DEPTH); count register 0..DEPTH.
- Accept (push) = in_valid & in_ready. Take (pop) = out_valid & out_ready.
- in_ready = (count != DEPTH). Combinational from state only, never from out_ready. No pass-through when full.
- out_valid = (count != 0).
- out_code = mem[rp] when out_valid, else 0.
- out_onehot = (1 << out_code) when out_valid, else all zeros. Exactly one bit set whenever out_valid = 1.
- level = count.
- Latency: a code accepted at edge N is visible on out_* after edge N (same-cycle bypass not permitted); minimum 1 cycle when the queue was empty.
- Push only: mem[wp] <= in_code, wp++, count++.
- Pop only: rp++, count--.
- Push and pop in the same cycle (only possible when 0 < count < DEPTH): both pointers advance, count unchanged.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.
- Handshake rules:
  - Producer holds in_code stable while in_valid is high and in_ready is low.
  - Block holds out_code/out_onehot stable while out_valid is high and out_ready is low.
  - out_ready with out_valid = 0 has no effect.
- flush: at the next edge, wp, rp and count are cleared to 0. flush overrides any push/pop in the same cycle; the code offered that cycle is not stored. Memory contents need not clear.
- Reset (rst_n low, any time, including mid-transfer): immediately wp = rp = 0, count = 0. Outputs then read out_valid = 0, out_onehot = 0, out_code = 0, level = 0, in_ready = 1. First accept is possible on the first edge after rst_n deasserts.
- No X on outputs after reset. Every in_code value 0..2**IN_W-1 is legal.

Test Plan (DEPTH=4, IN_W=3):
1. Reset and single transfer:
   - During reset: out_valid=0, out_onehot=8'h00, in_ready=1, level=0.
   - Push code 5 with out_ready=0 -> next cycle out_valid=1, out_onehot=8'h20, out_code=5, level=1.
   - Assert out_ready -> empty the following cycle.
2. Fill and stall:
   - Push codes 0,1,2,3 back-to-back with out_ready=0 -> in_ready=0, level=4.
   - A 5th push of code 7 held 3 cycles is not accepted.
   - Pop once -> in_ready=1; code 7 is accepted the next edge.
   - Drain order 8'h02,8'h04,8'h08,8'h80 (8'h01 was popped first).
3. Streaming with wrap:
   - in_valid and out_ready held high for 20 cycles with codes i mod 8.
   - After the first cycle, one output every cycle, level steady at 1, order preserved across multiple pointer wraps.
4. Simultaneous push/pop at level 2 -> level stays 2, head advances, new code appended at the tail.
5. Flush with concurrent push:
   - At level 3, assert flush together with in_valid (code 6) -> next cycle level=0, out_valid=0.
   - Subsequent push of code 6 emerges as 8'h40.
6. Asynchronous reset mid-stream:
   - Drop rst_n between clock edges at level 3 -> outputs clear immediately without a clock edge.
   - After release, push code 4 -> out_onehot=8'h10.
